eth_tx_frame_arbiter: RTL and testbench

//  Frame-granular round-robin arbiter that shares the 1G MAC TX FIFO AXI-stream input among NUM_PORTS sources.

---
 rtl/eth_tx_frame_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// eth_tx_frame_arbiter
//
// Frame-granular round-robin arbiter sharing the MAC TX FIFO AXI-stream input
// among NUM_PORTS sources. A grant is taken in IDLE, held from the first beat
// to tlast, and released through a one-cycle IDLE bubble. Frames longer than
// MAX_FRAME_BEATS are cut: the last forwarded beat carries tlast=1/tuser=1 and
// the rest of the source frame is drained and discarded.
//
// Handshake semantics: a beat moves on an interface in any cycle where both
// tvalid and tready are high at the rising clock edge. m_axis_tvalid never
// depends on m_axis_tready. s_axis_tready depends on m_axis_tready in PASS
// (pure pass-through) and is 1 for the granted port in DRAIN.
//
// Ports
//   logic_clk, logic_rst   clock, synchronous active-high reset
//   s_axis_*               per-port source streams, port i at slice i
//   m_axis_*               merged stream towards the MAC TX FIFO
//   port_enable            per-port arbitration eligibility (sampled in IDLE)
//   grant                  one-hot current owner, 0 in IDLE
//   busy                   1 in PASS or DRAIN
//   frame_done             1-cycle pulse after an m_axis tlast handshake
//   oversize               1-cycle pulse on the bit of a truncated port
//   dbg_state              FSM state (IDLE=0, PASS=1, DRAIN=2)
// -----------------------------------------------------------------------------
module eth_tx_frame_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int DATA_WIDTH      = 8,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_FRAME_BEATS = 1518
) (
  input  logic                             logic_clk,
  input  logic                             logic_rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS-1:0]             s_axis_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tuser,
  input  logic [NUM_PORTS-1:0]             port_enable,
  output logic [NUM_PORTS-1:0]             grant,
  output logic                             busy,
  output logic                             frame_done,
  output logic [NUM_PORTS-1:0]             oversize,
  output logic [1:0]                       dbg_state
);

  localparam int CNT_W = $clog2(MAX_FRAME_BEATS + 1);
  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(MAX_FRAME_BEATS - 1);
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_PORTS-1:0] r_grant, w_grant_nxt;
  logic [PTR_W-1:0]     r_gidx, w_gidx_nxt;
  logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]     r_count, w_count_nxt;
  logic                 r_frame_done, w_frame_done_nxt;
  logic [NUM_PORTS-1:0] r_oversize, w_oversize_nxt;

  // Granted-port view of the source buses.
  logic [DATA_WIDTH-1:0] w_src_data;
  logic [KEEP_WIDTH-1:0] w_src_keep;
  logic                  w_src_valid;
  logic                  w_src_last;
  logic                  w_src_user;

  assign w_src_data  = s_axis_tdata[r_gidx*DATA_WIDTH +: DATA_WIDTH];
  assign w_src_keep  = s_axis_tkeep[r_gidx*KEEP_WIDTH +: KEEP_WIDTH];
  assign w_src_valid = s_axis_tvalid[r_gidx];
  assign w_src_last  = s_axis_tlast[r_gidx];
  assign w_src_user  = s_axis_tuser[r_gidx];

  // Round-robin pick: first requester at (ptr+1), (ptr+2), ... with wrap.
  // The loop runs from the farthest candidate to the nearest so that the
  // nearest requester is the final assignment.
  logic [NUM_PORTS-1:0] w_req;
  logic                 w_req_any;
  logic [PTR_W-1:0]     w_pick;
  logic [PTR_W-1:0]     w_cand;

  always_comb begin
    w_req     = s_axis_tvalid & port_enable;
    w_req_any = 1'b0;
    w_pick    = '0;
    w_cand    = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      w_cand = PTR_W'((int'(r_ptr) + k) % NUM_PORTS);
      if (w_req[w_cand]) begin
        w_pick    = w_cand;
        w_req_any = 1'b1;
      end
    end
  end

  // The beat sitting at the length limit without tlast becomes the
  // truncation beat; its tlast/tuser are forced while it is presented.
  logic w_at_limit;

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_gidx_nxt       = r_gidx;
    w_ptr_nxt        = r_ptr;
    w_count_nxt      = r_count;
    w_frame_done_nxt = 1'b0;
    w_oversize_nxt   = '0;
    w_at_limit       = (r_count == LIMIT) && !w_src_last;
    s_axis_tready    = '0;
    m_axis_tdata     = '0;
    m_axis_tkeep     = '0;
    m_axis_tvalid    = 1'b0;
    m_axis_tlast     = 1'b0;
    m_axis_tuser     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_state_nxt = ST_PASS;
          w_gidx_nxt  = w_pick;
          w_grant_nxt = NUM_PORTS'(1) << w_pick;
        end
      end

      ST_PASS: begin
        m_axis_tdata  = w_src_data;
        m_axis_tkeep  = w_src_keep;
        m_axis_tvalid = w_src_valid;
        m_axis_tlast  = w_src_last | w_at_limit;
        m_axis_tuser  = w_src_user | w_at_limit;
        s_axis_tready = r_grant & {NUM_PORTS{m_axis_tready}};
        if (w_src_valid && m_axis_tready) begin
          w_count_nxt = r_count + 1'b1;
          if (w_src_last || w_at_limit) begin
            w_frame_done_nxt = 1'b1;
            w_ptr_nxt        = r_gidx;
            w_count_nxt      = '0;
            if (w_src_last) begin
              w_state_nxt = ST_IDLE;
              w_grant_nxt = '0;
            end else begin
              w_state_nxt    = ST_DRAIN;
              w_oversize_nxt = r_grant;
            end
          end
        end
      end

      ST_DRAIN: begin
        // Source keeps its grant so the tail of the oversize frame is
        // swallowed here instead of leaking into the next arbitration.
        s_axis_tready = r_grant;
        if (w_src_valid && w_src_last) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_gidx       <= '0;
      r_ptr        <= LAST_PORT;
      r_count      <= '0;
      r_frame_done <= 1'b0;
      r_oversize   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_gidx       <= w_gidx_nxt;
      r_ptr        <= w_ptr_nxt;
      r_count      <= w_count_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_oversize   <= w_oversize_nxt;
    end
  end

  assign grant      = r_grant;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_frame_done;
  assign oversize   = r_oversize;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_frame_arbiter
//
// Bench for eth_tx_frame_arbiter with NUM_PORTS=2, DATA_WIDTH=8,
// MAX_FRAME_BEATS=8. Frames are generated per port; the reference model turns
// each frame into the beats the MAC side must see (first MAX beats, last one
// marked tlast/tuser when the frame was too long) and pushes them onto a
// per-port expected queue. A monitor pops those queues on every m_axis
// handshake, and checks the frame_done/oversize pulses that follow a tlast.
// -----------------------------------------------------------------------------
module tb_eth_tx_frame_arbiter;

  localparam int NP   = 2;
  localparam int DW   = 8;
  localparam int KW   = 1;
  localparam int MAXB = 8;
  localparam int BW   = DW + KW + 2;      // {user, last, keep, data}
  localparam int EW   = BW + 1;           // {trunc, user, last, keep, data}
  localparam int LAST_B  = DW + KW;
  localparam int TRUNC_B = BW;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP*DW-1:0] s_tdata;
  logic [NP*KW-1:0] s_tkeep;
  logic [NP-1:0]    s_tvalid, s_tready, s_tlast, s_tuser;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tvalid, m_tready, m_tlast, m_tuser;
  logic [NP-1:0]    port_enable, grant, oversize;
  logic             busy, frame_done;
  logic [1:0]       dbg_state;

  eth_tx_frame_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_FRAME_BEATS(MAXB)
  ) dut (
    .logic_clk(clk), .logic_rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .port_enable(port_enable), .grant(grant), .busy(busy),
    .frame_done(frame_done), .oversize(oversize), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [BW-1:0] src_q0[$], src_q1[$];
  logic [EW-1:0] exp_q0[$], exp_q1[$];
  int n_checks = 0;
  int n_fail   = 0;
  int vld_pct  = 100;
  int rdy_pct  = 100;
  int order_log[$];
  int gap_log[$];
  int os_seen  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: source gets every beat; MAC side gets at most MAXB beats,
  // the MAXB-th one of an over-long frame forced to tlast=1, tuser=1.
  task automatic push_frame(input int p, input int len, input bit rand_user);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          u, l;
    logic [EW-1:0] e;
    for (int i = 0; i < len; i++) begin
      d = DW'($urandom);
      k = KW'($urandom);
      u = rand_user && ($urandom_range(3) == 0);
      l = (i == len - 1);
      if (p == 0) src_q0.push_back({u, l, k, d});
      else        src_q1.push_back({u, l, k, d});
      if (i < MAXB) begin
        if (len > MAXB && i == MAXB - 1) e = {1'b1, 1'b1, 1'b1, k, d};
        else                             e = {1'b0, u, l, k, d};
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
      end
    end
  endtask

  // ---------------------------------------------------------------- driver
  // One call = one clock: sample handshakes mid-cycle, update after the edge.
  task automatic tick();
    logic [NP-1:0] hs;
    logic [BW-1:0] b;
    int            qn;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        if (p == 0) void'(src_q0.pop_front());
        else        void'(src_q1.pop_front());
        s_tvalid[p] = 1'b0;
      end
      qn = (p == 0) ? src_q0.size() : src_q1.size();
      if (!s_tvalid[p] && qn != 0 && $urandom_range(99) < vld_pct) s_tvalid[p] = 1'b1;
      if (s_tvalid[p]) begin
        b = (p == 0) ? src_q0[0] : src_q1[0];
        s_tdata[p*DW +: DW] = b[DW-1:0];
        s_tkeep[p*KW +: KW] = b[DW+KW-1:DW];
        s_tlast[p]          = b[LAST_B];
        s_tuser[p]          = b[LAST_B+1];
      end else begin
        s_tdata[p*DW +: DW] = '0;
        s_tkeep[p*KW +: KW] = '0;
        s_tlast[p]          = 1'b0;
        s_tuser[p]          = 1'b0;
      end
    end
    m_tready = ($urandom_range(99) < rdy_pct);
  endtask

  // ---------------------------------------------------------------- monitor
  logic          pend     = 1'b0;
  logic [NP-1:0] pend_os  = '0;
  logic          in_frame = 1'b0;
  int            mon_port = -1;
  int            mon_beats = 0;
  int            cyc_n    = 0;
  int            last_end = 0;

  initial begin
    int            p;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (rst) begin
        pend      = 1'b0;
        in_frame  = 1'b0;
        mon_beats = 0;
        mon_port  = -1;
      end else begin
        if (pend) begin
          check("frame_done pulse", 32'(frame_done), 32'd1);
          check("oversize pulse", 32'(oversize), 32'(pend_os));
        end else begin
          check("frame_done quiet", 32'(frame_done), 32'd0);
          check("oversize quiet", 32'(oversize), 32'd0);
        end
        if (oversize != '0) os_seen++;
        pend = 1'b0;
        check("busy matches grant", 32'(busy), 32'(grant != '0));
        if (grant == '0) begin
          check("idle m_tvalid", 32'(m_tvalid), 32'd0);
          check("idle s_tready", 32'(s_tready), 32'd0);
        end
        if (m_tvalid && m_tready) begin
          check("grant onehot at beat", 32'($countones(grant)), 32'd1);
          p = (grant == 2'b01) ? 0 : ((grant == 2'b10) ? 1 : -1);
          if (p >= 0) begin
            if (!in_frame) begin
              in_frame  = 1'b1;
              mon_beats = 0;
              mon_port  = p;
              order_log.push_back(p);
              gap_log.push_back(cyc_n - last_end);
            end
            check("grant held in frame", 32'(p), 32'(mon_port));
            check("beat was expected", 32'((p == 0) ? exp_q0.size() : exp_q1.size()) != 0, 32'd1);
            if ((p == 0 && exp_q0.size() != 0) || (p == 1 && exp_q1.size() != 0)) begin
              e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              check("m_axis beat", 32'({m_tuser, m_tlast, m_tkeep, m_tdata}), 32'(e[BW-1:0]));
              mon_beats++;
              if (e[LAST_B]) begin
                pend     = 1'b1;
                pend_os  = e[TRUNC_B] ? ((p == 0) ? 2'b01 : 2'b10) : 2'b00;
                in_frame = 1'b0;
                last_end = cyc_n;
              end
            end
          end
        end
      end
    end
  end

  task automatic wait_done(input string name);
    int cyc = 0;
    while ((src_q0.size() != 0 || src_q1.size() != 0 || exp_q0.size() != 0 ||
            exp_q1.size() != 0 || busy || pend) && cyc < 3000) begin
      tick();
      cyc++;
    end
    tick();
    tick();
    check({name, " completes"}, 32'(cyc < 3000), 32'd1);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int exp_order[4];
    int found;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;

    s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0;
    s_tvalid = 2'b11; port_enable = 2'b11; m_tready = 1'b1;

    // Reset state with requests pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset grant", 32'(grant), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset oversize", 32'(oversize), 32'd0);
    check("reset m_tvalid", 32'(m_tvalid), 32'd0);
    check("reset s_tready", 32'(s_tready), 32'd0);
    s_tvalid = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Both ports saturated with 4-beat frames: strict alternation, 1 bubble
    vld_pct = 100; rdy_pct = 100;
    push_frame(0, 4, 1'b1); push_frame(1, 4, 1'b1);
    push_frame(0, 4, 1'b1); push_frame(1, 4, 1'b1);
    order_log.delete(); gap_log.delete();
    wait_done("round robin");
    check("rr frame count", 32'(order_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < order_log.size(); i++)
      check("rr order", 32'(order_log[i]), 32'(exp_order[i]));
    for (int i = 1; i < 4 && i < gap_log.size(); i++)
      check("rr bubble gap", 32'(gap_log[i]), 32'd2);

    // Disabled port never wins arbitration
    port_enable = 2'b01;
    push_frame(1, 3, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("disabled grant", 32'(grant), 32'd0);
      check("disabled m_tvalid", 32'(m_tvalid), 32'd0);
      check("disabled s_tready", 32'(s_tready), 32'd0);
    end
    port_enable = 2'b11;
    wait_done("re-enabled port");

    // Exactly MAX beats passes unmodified
    os_seen = 0;
    push_frame(0, MAXB, 1'b0);
    wait_done("max length frame");
    check("no oversize at max", 32'(os_seen), 32'd0);

    // MAX+4 beats: truncated, tail drained, under back-pressure
    rdy_pct = 50;
    push_frame(0, MAXB + 4, 1'b0);
    wait_done("oversize frame");
    check("one oversize pulse", 32'(os_seen), 32'd1);

    // Randomised traffic with random back-pressure
    for (int batch = 0; batch < 6; batch++) begin
      vld_pct = $urandom_range(40, 100);
      rdy_pct = $urandom_range(30, 100);
      for (int f = 0; f < 6; f++)
        push_frame($urandom_range(1), $urandom_range(1, MAXB + 4), 1'b1);
      wait_done("random batch");
    end
    rdy_pct = 50;
    for (int f = 0; f < 4; f++) push_frame(f % 2, MAXB - 1 + (f / 2), 1'b1);
    wait_done("limit neighbours");

    // Reset at beat 3 of a P1 frame
    vld_pct = 100; rdy_pct = 100;
    push_frame(1, 6, 1'b1);
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      tick();
      if (in_frame && mon_port == 1 && mon_beats == 3) found = 1;
    end
    check("reached beat 3", 32'(found), 32'd1);
    rst = 1'b1; m_tready = 1'b0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
    src_q0.delete(); src_q1.delete(); exp_q0.delete(); exp_q1.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort grant", 32'(grant), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort m_tvalid", 32'(m_tvalid), 32'd0);
    check("abort s_tready", 32'(s_tready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_frame(0, 3, 1'b1); push_frame(1, 3, 1'b1);
    order_log.delete();
    wait_done("post reset");
    check("post reset frames", 32'(order_log.size()), 32'd2);
    if (order_log.size() != 0) check("post reset first port", 32'(order_log[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
